// File: rtl/req_issuer.sv
// req_issuer: turns a bouncing push-button into counted requests and issues
// them one at a time to a downstream walker over a req/busy handshake, with
// saturation and acknowledge-timeout bookkeeping.
module req_issuer #(
    parameter int DEBOUNCE_WIDTH = 16,
    parameter int PENDING_WIDTH  = 2,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_btn,
    input  logic                     i_busy,
    output logic                     o_req,
    output logic [PENDING_WIDTH-1:0] o_pending,
    output logic                     o_overflow,
    output logic                     o_timeout
);

    localparam logic [DEBOUNCE_WIDTH-1:0] DB_ZERO   = {DEBOUNCE_WIDTH{1'b0}};
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_MAX    = {DEBOUNCE_WIDTH{1'b1}};
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONE    = DEBOUNCE_WIDTH'(1'b1);
    localparam logic [PENDING_WIDTH-1:0]  PEND_ZERO = {PENDING_WIDTH{1'b0}};
    localparam logic [PENDING_WIDTH-1:0]  PEND_MAX  = {PENDING_WIDTH{1'b1}};
    localparam logic [PENDING_WIDTH-1:0]  PEND_ONE  = PENDING_WIDTH'(1'b1);
    localparam logic [TIMEOUT_WIDTH-1:0]  TMO_ZERO  = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0]  TMO_MAX   = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0]  TMO_ONE   = TIMEOUT_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [1:0]                btn_sync_r;
    logic [1:0]                busy_sync_r;
    logic                      btn_s;
    logic                      busy_s;
    logic [DEBOUNCE_WIDTH-1:0] db_cnt_r;
    logic                      btn_stable_r;
    logic                      btn_stable_d_r;
    logic                      press_s;
    logic                      dec_s;
    state_t                    state_r;
    logic [TIMEOUT_WIDTH-1:0]  tmo_cnt_r;

    // Two-flop synchronizers for the asynchronous button and busy levels.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_sync_r  <= 2'b00;
            busy_sync_r <= 2'b00;
        end else begin
            btn_sync_r  <= {btn_sync_r[0], i_btn};
            busy_sync_r <= {busy_sync_r[0], i_busy};
        end
    end

    assign btn_s  = btn_sync_r[1];
    assign busy_s = busy_sync_r[1];

    // Debounce: accept a new level only after it has differed from the
    // accepted level for a full run of 2^DEBOUNCE_WIDTH consecutive cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            db_cnt_r       <= DB_ZERO;
            btn_stable_r   <= 1'b0;
            btn_stable_d_r <= 1'b0;
        end else begin
            btn_stable_d_r <= btn_stable_r;
            if (btn_s == btn_stable_r) begin
                db_cnt_r <= DB_ZERO;
            end else if (db_cnt_r == DB_MAX) begin
                btn_stable_r <= btn_s;
                db_cnt_r     <= DB_ZERO;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
            end
        end
    end

    // Press event: the cycle right after the accepted level rises.
    assign press_s = btn_stable_r & ~btn_stable_d_r;

    // A request is retired (acknowledged or abandoned) on this edge.
    assign dec_s = (state_r == ST_REQ) && (busy_s || (tmo_cnt_r == TMO_MAX));

    // Handshake FSM with registered request level and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            o_req     <= 1'b0;
            tmo_cnt_r <= TMO_ZERO;
            o_timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (o_pending != PEND_ZERO) begin
                        state_r   <= ST_REQ;
                        o_req     <= 1'b1;
                        tmo_cnt_r <= TMO_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                        o_req   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (busy_s) begin
                        state_r <= ST_WAIT_DONE;
                        o_req   <= 1'b0;
                    end else if (tmo_cnt_r == TMO_MAX) begin
                        state_r   <= ST_IDLE;
                        o_req     <= 1'b0;
                        o_timeout <= 1'b1;
                    end else begin
                        state_r   <= ST_REQ;
                        o_req     <= 1'b1;
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    o_req <= 1'b0;
                    if (!busy_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_req   <= 1'b0;
                end
            endcase
        end
    end

    // Pending-press counter: saturating increment on press, decrement on
    // retirement; a coincident press and retirement cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pending  <= PEND_ZERO;
            o_overflow <= 1'b0;
        end else begin
            case ({press_s, dec_s})
                2'b10: begin
                    if (o_pending == PEND_MAX) begin
                        o_overflow <= 1'b1;
                    end else begin
                        o_pending <= o_pending + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (o_pending != PEND_ZERO) begin
                        o_pending <= o_pending - PEND_ONE;
                    end else begin
                        o_pending <= o_pending;
                    end
                end
                default: begin
                    o_pending <= o_pending;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_issuer.sv
// Self-checking bench for req_issuer: directed table, hand-written corner
// sequences and randomized stimulus against a cycle-level behavioural model.
module tb_req_issuer;

    localparam int DW        = 2;
    localparam int PW        = 2;
    localparam int TW        = 4;
    localparam int DB_LEN    = 1 << DW;        // stable run needed to accept a level
    localparam int PEND_MAX  = (1 << PW) - 1;
    localparam int REQ_LIMIT = 1 << TW;        // cycles o_req may stay high unanswered

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_btn;
    logic          i_busy;
    logic          o_req;
    logic [PW-1:0] o_pending;
    logic          o_overflow;
    logic          o_timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model state (phase: 0 idle, 1 requesting, 2 waiting for busy low).
    int m_b1, m_b2, m_y1, m_y2;
    int m_stable, m_run, m_rise;
    int m_pend, m_ovf, m_tmo, m_phase, m_high;

    req_issuer #(.DEBOUNCE_WIDTH(DW), .PENDING_WIDTH(PW), .TIMEOUT_WIDTH(TW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_btn      (i_btn),
        .i_busy     (i_busy),
        .o_req      (o_req),
        .o_pending  (o_pending),
        .o_overflow (o_overflow),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int   cycles;
        logic btn;
        logic busy;
        int   exp_req;
        int   exp_pend;
    } vec_t;

    vec_t tbl[9];

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_y1 = 0; m_y2 = 0;
        m_stable = 0; m_run = 0; m_rise = 0;
        m_pend = 0; m_ovf = 0; m_tmo = 0; m_phase = 0; m_high = 0;
    endtask

    // One clock edge of the reference behaviour, using the levels sampled on it.
    task automatic model_step(input logic btn, input logic busy);
        int btn_s, busy_s, press, dec, n_stable, n_run, n_phase, n_high;
        btn_s    = m_b2;
        busy_s   = m_y2;
        press    = m_rise;
        dec      = 0;
        n_stable = m_stable;
        n_phase  = m_phase;
        n_high   = m_high;
        if (btn_s != m_stable) begin
            n_run = m_run + 1;
            if (n_run == DB_LEN) begin
                n_stable = btn_s;
                n_run    = 0;
            end
        end else begin
            n_run = 0;
        end
        case (m_phase)
            0: if (m_pend != 0) begin n_phase = 1; n_high = 1; end
            1: begin
                if (busy_s != 0) begin
                    n_phase = 2; dec = 1;
                end else if (m_high == REQ_LIMIT) begin
                    n_phase = 0; dec = 1; m_tmo = 1;
                end else begin
                    n_high = m_high + 1;
                end
            end
            default: if (busy_s == 0) n_phase = 0;
        endcase
        if (press != 0 && dec == 0) begin
            if (m_pend == PEND_MAX) m_ovf = 1;
            else m_pend = m_pend + 1;
        end else if (dec != 0 && press == 0) begin
            m_pend = m_pend - 1;
        end
        m_rise   = (n_stable == 1 && m_stable == 0) ? 1 : 0;
        m_stable = n_stable;
        m_run    = n_run;
        m_phase  = n_phase;
        m_high   = n_high;
        m_b2 = m_b1; m_b1 = int'(btn);
        m_y2 = m_y1; m_y1 = int'(busy);
    endtask

    task automatic check_model(input string name);
        logic [PW+2:0] act, exp;
        act = {o_req, o_pending, o_overflow, o_timeout};
        exp = {(m_phase == 1) ? 1'b1 : 1'b0, PW'(m_pend), m_ovf[0], m_tmo[0]};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t {req,pending,ovf,tmo} actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, expected);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, compare on the falling edge.
    task automatic step(input logic btn, input logic busy);
        i_btn  = btn;
        i_busy = busy;
        @(posedge i_clk);
        model_step(btn, busy);
        @(negedge i_clk);
        check_model("model");
    endtask

    // Assert reset away from any clock edge and confirm outputs clear at once.
    task automatic do_reset(input string name);
        i_rst = 1'b1;
        #1;
        check_val({name, "_req"}, int'(o_req), 0);
        check_val({name, "_pend"}, int'(o_pending), 0);
        check_val({name, "_flags"}, int'({o_overflow, o_timeout}), 0);
        model_reset();
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        int hi_cnt, max_pend, btn_left, busy_left;
        logic rb, ry;

        tbl[0] = '{6, 1'b1, 1'b0, 0, 0};
        tbl[1] = '{1, 1'b1, 1'b0, 0, 1};
        tbl[2] = '{1, 1'b1, 1'b0, 1, 1};
        tbl[3] = '{2, 1'b1, 1'b0, 1, 1};
        tbl[4] = '{2, 1'b0, 1'b1, 1, 1};
        tbl[5] = '{1, 1'b0, 1'b1, 0, 0};
        tbl[6] = '{7, 1'b0, 1'b1, 0, 0};
        tbl[7] = '{2, 1'b0, 1'b0, 0, 0};
        tbl[8] = '{4, 1'b0, 1'b0, 0, 0};

        i_rst  = 1'b0;
        i_btn  = 1'b0;
        i_busy = 1'b0;
        model_reset();
        #2;
        do_reset("por");

        // Clean press with a walker answering 3 cycles after the request.
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) step(tbl[r].btn, tbl[r].busy);
            check_val($sformatf("clean_req_row%0d", r), int'(o_req), tbl[r].exp_req);
            check_val($sformatf("clean_pend_row%0d", r), int'(o_pending), tbl[r].exp_pend);
        end

        // Bounce: 3-cycle pulses never reach the debounce threshold.
        do_reset("bounce_rst");
        for (int rep = 0; rep < 5; rep++) begin
            for (int c = 0; c < 6; c++) begin
                step((c < 3) ? 1'b1 : 1'b0, 1'b0);
                check_val("bounce_pend", int'(o_pending), 0);
                check_val("bounce_req", int'(o_req), 0);
            end
        end

        // Timeout: one press, walker never answers.
        do_reset("tmo_rst");
        hi_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step((c < 4) ? 1'b1 : 1'b0, 1'b0);
            if (o_req === 1'b1) hi_cnt++;
        end
        check_val("timeout_req_cycles", hi_cnt, REQ_LIMIT);
        check_val("timeout_flag", int'(o_timeout), 1);
        check_val("timeout_pend", int'(o_pending), 0);
        check_val("timeout_req_low", int'(o_req), 0);

        // Overflow: five back-to-back presses, walker never answers.
        do_reset("ovf_rst");
        max_pend = 0;
        for (int c = 0; c < 40; c++) begin
            step((c % 8 < 4) ? 1'b1 : 1'b0, 1'b0);
            if (int'(o_pending) > max_pend) max_pend = int'(o_pending);
        end
        check_val("overflow_flag", int'(o_overflow), 1);
        check_val("overflow_max_pend", max_pend, PEND_MAX);

        // Simultaneity: third press lands on the acknowledge edge with 2 pending.
        do_reset("sim_rst");
        for (int k = 1; k <= 25; k++) begin
            step((k <= 20 && ((k - 1) % 8) < 4) ? 1'b1 : 1'b0, (k >= 21) ? 1'b1 : 1'b0);
            if (k == 22) begin
                check_val("simul_pre_pend", int'(o_pending), 2);
                check_val("simul_pre_req", int'(o_req), 1);
            end
            if (k == 23) begin
                check_val("simul_pend", int'(o_pending), 2);
                check_val("simul_req", int'(o_req), 0);
                check_val("simul_ovf", int'(o_overflow), 0);
            end
        end
        check_val("wait_pend", int'(o_pending), 2);

        // Reset in WAIT_DONE, then a held button needs the full debounce again.
        i_btn = 1'b1;
        do_reset("wait_rst");
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0);
            if (k == 6) check_val("post_rst_pend6", int'(o_pending), 0);
            if (k == 7) check_val("post_rst_pend7", int'(o_pending), 1);
            if (k == 8) check_val("post_rst_req8", int'(o_req), 1);
        end
        check_val("pre_reset_req", int'(o_req), 1);
        do_reset("req_rst");

        // Randomized run-length stimulus against the model, with occasional resets.
        rb = 1'b0; ry = 1'b0; btn_left = 0; busy_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (btn_left == 0) begin
                rb = ~rb;
                btn_left = int'($urandom_range(1, 10));
            end
            if (busy_left == 0) begin
                ry = ~ry;
                busy_left = int'($urandom_range(1, 25));
            end
            step(rb, ry);
            btn_left--;
            busy_left--;
            if (c % 997 == 996) do_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
